control_sequencer: RTL and testbench

Parametrised successor to the CPU control FSM. It sequences file load, fetch, decode and the LD/ST, branch/JMP/RET, ALU, crypto and END instruction classes. Additions over the previous generation:
- bounded-wait watchdogs on every unit handshake
- return-stack depth tracking with overflow/underflow detection
- illegal-opcode trapping, a sticky fault code
- single-step mode and a retired-instruction counter

It sits between instruction memory/PC, data memory/SP, the ALU and the crypto core.

---
 rtl/control_sequencer_if.sv | 71 +++++++
 rtl/control_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_if
// Description : Unit handshake and strobe bundle between the control
//               sequencer and the PC, memory, stack, ALU and crypto units.
// Revision    : 1.0
// ============================================================================
interface control_sequencer_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 16
);
    logic                bgn;
    logic                step_en;
    logic                step_go;
    logic                fin_file;
    logic                fin_crypto;
    logic                Alu_busy;
    logic [OPCODE_W-1:0] opcode;
    logic [3:0]          flags;
    logic                register;

    logic [3:0]          reg_signal;
    logic                STA_signal;
    logic                LDA_signal;
    logic                mem_read;
    logic                mem_write;
    logic                PUSH;
    logic                POP;
    logic                read_file;
    logic                read_memory;
    logic                Increm_PC;
    logic                pc_save_address_from_counter;
    logic                pc_save_address_from_instr_mem;
    logic                pc_save_address_from_data_mem;
    logic                Start_ALU_operation;
    logic                Load_data;
    logic                Store_data;
    logic                start_crypt;
    logic                start_decrypt;
    logic                start_execute_crypto;
    logic                halted;
    logic                fault;
    logic [2:0]          fault_code;
    logic [7:0]          stack_level;
    logic [CNT_W-1:0]    instr_count;

    modport slave (
        input  bgn, step_en, step_go, fin_file, fin_crypto, Alu_busy,
               opcode, flags, register,
        output reg_signal, STA_signal, LDA_signal, mem_read, mem_write,
               PUSH, POP, read_file, read_memory, Increm_PC,
               pc_save_address_from_counter, pc_save_address_from_instr_mem,
               pc_save_address_from_data_mem, Start_ALU_operation,
               Load_data, Store_data, start_crypt, start_decrypt,
               start_execute_crypto, halted, fault, fault_code,
               stack_level, instr_count
    );

    modport master (
        output bgn, step_en, step_go, fin_file, fin_crypto, Alu_busy,
               opcode, flags, register,
        input  reg_signal, STA_signal, LDA_signal, mem_read, mem_write,
               PUSH, POP, read_file, read_memory, Increm_PC,
               pc_save_address_from_counter, pc_save_address_from_instr_mem,
               pc_save_address_from_data_mem, Start_ALU_operation,
               Load_data, Store_data, start_crypt, start_decrypt,
               start_execute_crypto, halted, fault, fault_code,
               stack_level, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : CPU control FSM with watchdogs, return-stack tracking,
//               opcode trapping, single-step and retired-instruction count.
// Revision    : 1.0
// ============================================================================
module control_sequencer #(
    parameter int OPCODE_W    = 6,
    parameter int STACK_DEPTH = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  wire                 clk,
    input  wire                 rst,
    control_sequencer_if.slave  bus
);
    typedef enum logic [4:0] {
        S_IDLE, S_READ_FILE, S_WAIT_FILE, S_FETCH, S_LATCH, S_DECODE,
        S_REG_ST, S_MEM_WR, S_MEM_RD, S_REG_LD, S_ACC_ST, S_ACC_LD,
        S_BR_EVAL, S_JUMP, S_PUSH_ST, S_POP_ST, S_PC_RESTORE,
        S_ALU_SEL, S_ALU_START, S_ALU_WAIT,
        S_CR_READ, S_CR_LOAD, S_CR_START, S_CR_WAIT, S_CR_STORE, S_CR_WRITE,
        S_COMPLETE, S_STEP_WAIT, S_HALT, S_FAULT
    } state_t;

    typedef struct packed {
        logic [3:0] reg_sig;
        logic sta, lda, mrd, mwr, push, pop, rdf, rdm, ipc, pcc, pci, pcd;
        logic alu, ldd, std, scr, sdc, sex, hlt, flt;
    } out_t;

    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 2);
    localparam logic [WAIT_W-1:0] c_LAST = WAIT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t             r_state, w_next;
    out_t               r_out, w_out;
    logic [3:0]         r_op;
    logic               r_reg;
    logic               w_reg;
    logic               w_taken;
    logic               w_timeout;
    logic [2:0]         r_fcode, w_fcode;
    logic [7:0]         r_stack;
    logic [CNT_W-1:0]   r_count;
    logic [WAIT_W-1:0]  r_wait;

    // The register select is needed in the very cycle DECODE exits.
    assign w_reg     = (r_state == S_DECODE) ? bus.register : r_reg;
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_wait == c_LAST);

    always_comb begin
        w_next  = r_state;
        w_fcode = r_fcode;
        w_taken = 1'b0;
        case (r_op)
            4'd5:    w_taken = bus.flags[3];
            4'd6:    w_taken = bus.flags[2];
            4'd7:    w_taken = bus.flags[1];
            4'd8:    w_taken = bus.flags[0];
            4'd9:    w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
        case (r_state)
            S_IDLE:      if (bus.bgn) w_next = S_READ_FILE;
            S_READ_FILE: w_next = S_WAIT_FILE;
            S_WAIT_FILE: if (bus.fin_file) w_next = S_FETCH;
            S_FETCH:     w_next = S_LATCH;
            S_LATCH:     w_next = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == '0) begin
                    w_next = S_HALT;
                end else if (bus.opcode <= OPCODE_W'(4)) begin
                    case (bus.opcode[2:0])
                        3'd1:    w_next = S_REG_ST;
                        3'd3:    w_next = S_ACC_ST;
                        default: w_next = S_MEM_RD;
                    endcase
                end else if (bus.opcode <= OPCODE_W'(11)) begin
                    w_next = S_BR_EVAL;
                end else if (bus.opcode <= OPCODE_W'(29)) begin
                    w_next = S_ALU_SEL;
                end else if (bus.opcode == OPCODE_W'(30)) begin
                    w_next = S_CR_READ;
                end else begin
                    w_next  = S_FAULT;
                    w_fcode = 3'd1;
                end
            end
            S_REG_ST, S_ACC_ST: w_next = S_MEM_WR;
            S_MEM_WR:    w_next = S_COMPLETE;
            S_MEM_RD:    w_next = (r_op == 4'd2) ? S_REG_LD : S_ACC_LD;
            S_REG_LD, S_ACC_LD: w_next = S_COMPLETE;
            S_BR_EVAL: begin
                if (r_op == 4'd10) begin
                    if (r_stack == 8'(STACK_DEPTH)) begin
                        w_next  = S_FAULT;
                        w_fcode = 3'd4;
                    end else begin
                        w_next = S_PUSH_ST;
                    end
                end else if (r_op == 4'd11) begin
                    if (r_stack == 8'd0) begin
                        w_next  = S_FAULT;
                        w_fcode = 3'd5;
                    end else begin
                        w_next = S_POP_ST;
                    end
                end else begin
                    w_next = w_taken ? S_JUMP : S_COMPLETE;
                end
            end
            S_PUSH_ST:    w_next = S_JUMP;
            S_JUMP:       w_next = S_COMPLETE;
            S_POP_ST:     w_next = S_PC_RESTORE;
            S_PC_RESTORE: w_next = S_COMPLETE;
            S_ALU_SEL:    w_next = S_ALU_START;
            S_ALU_START:  w_next = S_ALU_WAIT;
            S_ALU_WAIT: begin
                if (!bus.Alu_busy) begin
                    w_next = S_COMPLETE;
                end else if (w_timeout) begin
                    w_next  = S_FAULT;
                    w_fcode = 3'd2;
                end
            end
            S_CR_READ:  w_next = S_CR_LOAD;
            S_CR_LOAD:  w_next = S_CR_START;
            S_CR_START: w_next = S_CR_WAIT;
            S_CR_WAIT: begin
                if (bus.fin_crypto) begin
                    w_next = S_CR_STORE;
                end else if (w_timeout) begin
                    w_next  = S_FAULT;
                    w_fcode = 3'd3;
                end
            end
            S_CR_STORE:  w_next = S_CR_WRITE;
            S_CR_WRITE:  w_next = S_COMPLETE;
            S_COMPLETE:  w_next = bus.step_en ? S_STEP_WAIT : S_FETCH;
            S_STEP_WAIT: if (bus.step_go) w_next = S_FETCH;
            S_HALT:      if (!bus.bgn) w_next = S_IDLE;
            S_FAULT:     w_next = S_FAULT;
            default:     w_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered with it.
    always_comb begin
        w_out = '0;
        case (w_next)
            S_READ_FILE:  w_out.rdf = 1'b1;
            S_FETCH: begin
                w_out.rdm = 1'b1;
                w_out.ipc = 1'b1;
            end
            S_LATCH:      w_out.pcc = 1'b1;
            S_REG_ST, S_ALU_SEL: w_out.reg_sig = w_reg ? 4'b0010 : 4'b1000;
            S_REG_LD:     w_out.reg_sig = r_reg ? 4'b0001 : 4'b0100;
            S_MEM_WR, S_CR_WRITE: w_out.mwr = 1'b1;
            S_MEM_RD, S_CR_READ:  w_out.mrd = 1'b1;
            S_ACC_ST:     w_out.sta = 1'b1;
            S_ACC_LD:     w_out.lda = 1'b1;
            S_JUMP:       w_out.pci = 1'b1;
            S_PUSH_ST: begin
                w_out.push = 1'b1;
                w_out.mwr  = 1'b1;
            end
            S_POP_ST: begin
                w_out.pop = 1'b1;
                w_out.mrd = 1'b1;
            end
            S_PC_RESTORE: w_out.pcd = 1'b1;
            S_ALU_START:  w_out.alu = 1'b1;
            S_CR_LOAD: begin
                w_out.ldd = 1'b1;
                w_out.scr = ~r_reg;
                w_out.sdc = r_reg;
            end
            S_CR_START:   w_out.sex = 1'b1;
            S_CR_STORE:   w_out.std = 1'b1;
            S_HALT:       w_out.hlt = 1'b1;
            S_FAULT:      w_out.flt = 1'b1;
            default:      w_out = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_op    <= '0;
            r_reg   <= 1'b0;
            r_fcode <= '0;
            r_stack <= '0;
            r_count <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= w_out;
            if (r_state == S_DECODE) begin
                r_op  <= bus.opcode[3:0];
                r_reg <= bus.register;
            end
            if (w_next == S_FAULT && r_state != S_FAULT)
                r_fcode <= w_fcode;
            if (w_next == S_PUSH_ST)
                r_stack <= r_stack + 8'd1;
            else if (w_next == S_POP_ST)
                r_stack <= r_stack - 8'd1;
            if (w_next == S_COMPLETE || (w_next == S_HALT && r_state != S_HALT))
                r_count <= r_count + 1'b1;
            // Cleared outside the wait states, so the first wait cycle sees 0.
            if (r_state == S_ALU_WAIT || r_state == S_CR_WAIT) begin
                if (r_wait != '1)
                    r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
        end
    end

    assign bus.reg_signal                     = r_out.reg_sig;
    assign bus.STA_signal                     = r_out.sta;
    assign bus.LDA_signal                     = r_out.lda;
    assign bus.mem_read                       = r_out.mrd;
    assign bus.mem_write                      = r_out.mwr;
    assign bus.PUSH                           = r_out.push;
    assign bus.POP                            = r_out.pop;
    assign bus.read_file                      = r_out.rdf;
    assign bus.read_memory                    = r_out.rdm;
    assign bus.Increm_PC                      = r_out.ipc;
    assign bus.pc_save_address_from_counter   = r_out.pcc;
    assign bus.pc_save_address_from_instr_mem = r_out.pci;
    assign bus.pc_save_address_from_data_mem  = r_out.pcd;
    assign bus.Start_ALU_operation            = r_out.alu;
    assign bus.Load_data                      = r_out.ldd;
    assign bus.Store_data                     = r_out.std;
    assign bus.start_crypt                    = r_out.scr;
    assign bus.start_decrypt                  = r_out.sdc;
    assign bus.start_execute_crypto           = r_out.sex;
    assign bus.halted                         = r_out.hlt;
    assign bus.fault                          = r_out.flt;
    assign bus.fault_code                     = r_fcode;
    assign bus.stack_level                    = r_stack;
    assign bus.instr_count                    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed and random instruction streams checked against an
//               instruction-level model of strobe sequences and counters.
// Revision    : 1.0
// ============================================================================
module tb_control_sequencer;
    localparam int OW = 6;
    localparam int SD = 2;
    localparam int TO = 64;
    localparam int CW = 16;

    localparam logic [23:0] B_FAULT = 24'h000001, B_HALT = 24'h000002,
                            B_EXC   = 24'h000004, B_DEC  = 24'h000008,
                            B_CRY   = 24'h000010, B_ST   = 24'h000020,
                            B_LD    = 24'h000040, B_ALU  = 24'h000080,
                            B_PDM   = 24'h000100, B_PIM  = 24'h000200,
                            B_PCC   = 24'h000400, B_IPC  = 24'h000800,
                            B_RM    = 24'h001000, B_RF   = 24'h002000,
                            B_POP   = 24'h004000, B_PUSH = 24'h008000,
                            B_MW    = 24'h010000, B_MR   = 24'h020000,
                            B_LDA   = 24'h040000, B_STA  = 24'h080000,
                            R_STX   = 24'h800000, R_LDX  = 24'h400000,
                            R_STY   = 24'h200000, R_LDY  = 24'h100000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_sequencer_if #(.OPCODE_W(OW), .CNT_W(CW)) bus ();

    control_sequencer #(
        .OPCODE_W(OW), .STACK_DEPTH(SD), .TIMEOUT_CYC(TO), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int m_stack, m_count, m_code;
    bit m_fault, m_halt;
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];

    function automatic logic [23:0] obs_word();
        return {bus.reg_signal, bus.STA_signal, bus.LDA_signal, bus.mem_read,
                bus.mem_write, bus.PUSH, bus.POP, bus.read_file, bus.read_memory,
                bus.Increm_PC, bus.pc_save_address_from_counter,
                bus.pc_save_address_from_instr_mem, bus.pc_save_address_from_data_mem,
                bus.Start_ALU_operation, bus.Load_data, bus.Store_data,
                bus.start_crypt, bus.start_decrypt, bus.start_execute_crypto,
                bus.halted, bus.fault};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Instruction-level model: expected non-zero strobe words and side effects.
    task automatic model(input int op, input bit rg, input logic [3:0] fl,
                         input int lat, output int exp_exit);
        int  flt;
        bit  ok, taken;
        flt      = 0;
        ok       = (lat > 0) && (lat <= TO);
        exp_exit = -1;
        exp_q.push_back(B_RM | B_IPC);
        exp_q.push_back(B_PCC);
        if (op == 0) begin
            exp_q.push_back(B_HALT);
            m_halt  = 1'b1;
            m_count = (m_count + 1) % (1 << CW);
            return;
        end
        if (op > 30) flt = 1;
        else if (op == 1) begin exp_q.push_back(rg ? R_STY : R_STX); exp_q.push_back(B_MW); end
        else if (op == 2) begin exp_q.push_back(B_MR); exp_q.push_back(rg ? R_LDY : R_LDX); end
        else if (op == 3) begin exp_q.push_back(B_STA); exp_q.push_back(B_MW); end
        else if (op == 4) begin exp_q.push_back(B_MR); exp_q.push_back(B_LDA); end
        else if (op <= 9) begin
            taken = (op == 5) ? fl[3] : (op == 6) ? fl[2] : (op == 7) ? fl[1] :
                    (op == 8) ? fl[0] : 1'b1;
            if (taken) exp_q.push_back(B_PIM);
        end else if (op == 10) begin
            if (m_stack == SD) flt = 4;
            else begin exp_q.push_back(B_PUSH | B_MW); exp_q.push_back(B_PIM); m_stack++; end
        end else if (op == 11) begin
            if (m_stack == 0) flt = 5;
            else begin exp_q.push_back(B_POP | B_MR); exp_q.push_back(B_PDM); m_stack--; end
        end else if (op <= 29) begin
            exp_q.push_back(rg ? R_STY : R_STX);
            exp_q.push_back(B_ALU);
            exp_exit = ok ? lat + 1 : TO + 1;
            if (!ok) flt = 2;
        end else begin
            exp_q.push_back(B_MR);
            exp_q.push_back(B_LD | (rg ? B_DEC : B_CRY));
            exp_q.push_back(B_EXC);
            exp_exit = ok ? lat + 1 : TO + 1;
            if (ok) begin exp_q.push_back(B_ST); exp_q.push_back(B_MW); end
            else flt = 3;
        end
        if (flt != 0) begin
            exp_q.push_back(B_FAULT);
            m_fault = 1'b1;
            m_code  = flt;
        end else begin
            m_count = (m_count + 1) % (1 << CW);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.bgn = 1'b0;
        #1;
        chk("rst_outputs", 32'(obs_word()), 32'h0);
        chk("rst_stack", 32'(bus.stack_level), 32'h0);
        chk("rst_count", 32'(bus.instr_count), 32'h0);
        chk("rst_fcode", 32'(bus.fault_code), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        m_stack = 0; m_count = 0; m_code = 0; m_fault = 1'b0; m_halt = 1'b0;
    endtask

    task automatic run_instr(input bit first, input bit step, input int op, input bit rg,
                             input logic [3:0] fl, input int lat, input string tag);
        logic [CW-1:0] c0;
        logic [23:0]   w;
        int  k, obs_exit, exp_exit, idx;
        bit  marked, done;
        exp_q.delete();
        obs_q.delete();
        if (first) exp_q.push_back(B_RF);
        model(op, rg, fl, lat, exp_exit);
        bus.opcode     = OW'(op);
        bus.register   = rg;
        bus.flags      = fl;
        bus.Alu_busy   = 1'b1;
        bus.fin_crypto = 1'b0;
        bus.step_en    = step;
        if (first) begin bus.fin_file = 1'b0; bus.bgn = 1'b1; end
        c0 = bus.instr_count;
        marked = 1'b0; k = 0; obs_exit = -1; done = 1'b0;
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            @(posedge clk);
            #1;
            w = obs_word();
            if (w != 24'h0) obs_q.push_back(w);
            if (marked) begin
                k++;
                if (obs_exit < 0 && (w != 24'h0 || bus.instr_count != c0)) obs_exit = k;
            end
            if ((w & (B_ALU | B_EXC)) != 24'h0) begin marked = 1'b1; k = 0; end
            if (marked && lat > 0 && k == lat) begin bus.Alu_busy = 1'b0; bus.fin_crypto = 1'b1; end
            if (first && cyc == 3) bus.fin_file = 1'b1;
            bus.step_go = step && (cyc == 3);
            done = (bus.instr_count != c0) || bus.fault || bus.halted;
        end
        bus.step_go = 1'b0;
        chk({tag, " ended"}, 32'(done), 32'h1);
        chk({tag, " len"}, obs_q.size(), exp_q.size());
        idx = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] != exp_q[i]) begin idx = i; break; end
        chk({tag, " seq"}, (obs_q.size() > idx) ? 32'(obs_q[idx]) : 32'h0,
                           (exp_q.size() > idx) ? 32'(exp_q[idx]) : 32'h0);
        chk({tag, " count"}, 32'(bus.instr_count), 32'(m_count));
        chk({tag, " stack"}, 32'(bus.stack_level), 32'(m_stack));
        chk({tag, " fault"}, 32'(bus.fault), 32'(m_fault));
        chk({tag, " fcode"}, 32'(bus.fault_code), 32'(m_code));
        chk({tag, " halted"}, 32'(bus.halted), 32'(m_halt));
        if (exp_exit >= 0) chk({tag, " exit_cycle"}, obs_exit, exp_exit);
    endtask

    initial begin
        int op, lat;
        bit first;
        logic [CW-1:0] hold;
        rst = 1'b1;
        bus.bgn = 1'b0; bus.step_en = 1'b0; bus.step_go = 1'b0; bus.fin_file = 1'b0;
        bus.fin_crypto = 1'b0; bus.Alu_busy = 1'b0; bus.opcode = '0;
        bus.flags = 4'h0; bus.register = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run_instr(1, 0, 12, 0, 4'h0, 5, "alu12");
        for (int i = 1; i <= 4; i++) run_instr(0, 0, i, 1, 4'h0, 0, $sformatf("ldst%0d", i));
        run_instr(0, 0, 5, 0, 4'b1000, 0, "br5_taken");
        run_instr(0, 0, 5, 0, 4'b0000, 0, "br5_not");
        run_instr(0, 0, 9, 0, 4'b0000, 0, "br9");
        for (int i = 6; i <= 8; i++) run_instr(0, 0, i, 0, 4'($urandom), 0, $sformatf("br%0d", i));

        run_instr(0, 0, 10, 0, 4'h0, 0, "jmp1");
        run_instr(0, 0, 10, 0, 4'h0, 0, "jmp2");
        run_instr(0, 0, 10, 0, 4'h0, 0, "jmp_ovf");
        hold = bus.instr_count;
        repeat (5) @(posedge clk);
        #1;
        chk("fault_sticky", 32'(bus.fault), 32'h1);
        chk("fault_count_frozen", 32'(bus.instr_count), 32'(hold));
        do_reset();
        run_instr(1, 0, 11, 0, 4'h0, 0, "ret_unf");

        do_reset();
        run_instr(1, 0, 30, 0, 4'h0, 0, "cr_never");
        do_reset();
        run_instr(1, 0, 30, 0, 4'h0, 64, "cr_last");
        run_instr(0, 0, 30, 1, 4'h0, 3, "cr_dec");
        run_instr(0, 0, 20, 1, 4'h0, 64, "alu_last");
        run_instr(0, 0, 21, 0, 4'h0, 65, "alu_late");
        do_reset();

        first = 1'b1;
        for (int n = 0; n < 40; n++) begin
            op  = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 11) : $urandom_range(1, 30);
            lat = $urandom_range(1, 8);
            run_instr(first, 0, op, 1'($urandom), 4'($urandom), lat, $sformatf("rnd%0d_op%0d", n, op));
            first = 1'b0;
            if (m_fault) begin do_reset(); first = 1'b1; end
        end

        do_reset();
        run_instr(1, 1, 1, 0, 4'h0, 0, "step0");
        run_instr(0, 1, 2, 0, 4'h0, 0, "step1");
        run_instr(0, 1, 13, 0, 4'h0, 2, "step2");
        run_instr(0, 1, 30, 0, 4'h0, 2, "step3");
        run_instr(0, 1, 0, 0, 4'h0, 0, "halt");
        hold = bus.instr_count;
        repeat (3) @(posedge clk);
        #1;
        chk("halt_stays", 32'(bus.halted), 32'h1);
        chk("halt_count_once", 32'(bus.instr_count), 32'(hold));
        bus.bgn = 1'b0;
        @(posedge clk);
        #1;
        chk("halt_to_idle", 32'(obs_word()), 32'h0);
        m_halt = 1'b0;
        run_instr(1, 0, 31, 0, 4'h0, 0, "illegal");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
